// File: rtl/fadd_arb.sv
// Two-requester round-robin front end for a shared pipelined FP adder.
// Operands are registered on grant and results are routed back by requester id.
module fadd_arb #(
    parameter int FADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] fadd_x1,
    output logic [31:0] fadd_x2,
    input  logic [31:0] fadd_y,
    output logic        busy
);

    localparam int DEPTH = FADD_LAT + 1;

    function automatic logic [31:0] flip_sign(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    logic             rr_ptr_r;
    logic             ack0_s;
    logic             ack1_s;
    logic             grant_s;
    logic [31:0]      sel_a_s;
    logic [31:0]      sel_b_s;
    logic             sel_op_s;
    logic [DEPTH-1:0] stage_valid_r;
    logic [DEPTH-1:0] stage_id_r;
    logic             rvalid0_r;
    logic             rvalid1_r;
    logic [31:0]      rdata0_r;
    logic [31:0]      rdata1_r;
    logic [31:0]      fadd_x1_r;
    logic [31:0]      fadd_x2_r;
    logic             last_valid_s;
    logic             last_id_s;

    // Grant selection: a lone requester wins, contention is settled by rr_ptr_r.
    always_comb begin
        ack0_s = 1'b0;
        ack1_s = 1'b0;
        if (rst) begin
            ack0_s = 1'b0;
            ack1_s = 1'b0;
        end else if (req0 && req1) begin
            if (rr_ptr_r) begin
                ack1_s = 1'b1;
            end else begin
                ack0_s = 1'b1;
            end
        end else if (req0) begin
            ack0_s = 1'b1;
        end else if (req1) begin
            ack1_s = 1'b1;
        end else begin
            ack0_s = 1'b0;
            ack1_s = 1'b0;
        end
    end

    assign grant_s      = ack0_s | ack1_s;
    assign sel_a_s      = ack1_s ? a1 : a0;
    assign sel_b_s      = ack1_s ? b1 : b0;
    assign sel_op_s     = ack1_s ? op1 : op0;
    assign last_valid_s = stage_valid_r[DEPTH-1];
    assign last_id_s    = stage_id_r[DEPTH-1];

    // Round-robin pointer favours the requester that did not win last.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= 1'b0;
        end else if (grant_s) begin
            rr_ptr_r <= ~ack1_s;
        end
    end

    // Operand registers feeding the shared adder; subtraction is a sign flip of b.
    always_ff @(posedge clk) begin
        if (rst) begin
            fadd_x1_r <= 32'd0;
            fadd_x2_r <= 32'd0;
        end else if (grant_s) begin
            fadd_x1_r <= sel_a_s;
            fadd_x2_r <= sel_op_s ? flip_sign(sel_b_s) : sel_b_s;
        end
    end

    // In-flight tracker, aligned so the last stage coincides with fadd_y being valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_r <= '0;
            stage_id_r    <= '0;
        end else begin
            stage_valid_r[0] <= grant_s;
            stage_id_r[0]    <= ack1_s;
            for (int i = 1; i < DEPTH; i++) begin
                stage_valid_r[i] <= stage_valid_r[i-1];
                stage_id_r[i]    <= stage_id_r[i-1];
            end
        end
    end

    // Result capture and steering; rdata holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= 32'd0;
            rdata1_r  <= 32'd0;
        end else begin
            rvalid0_r <= last_valid_s & ~last_id_s;
            rvalid1_r <= last_valid_s & last_id_s;
            if (last_valid_s && !last_id_s) begin
                rdata0_r <= fadd_y;
            end
            if (last_valid_s && last_id_s) begin
                rdata1_r <= fadd_y;
            end
        end
    end

    assign ack0    = ack0_s;
    assign ack1    = ack1_s;
    assign rvalid0 = rvalid0_r;
    assign rvalid1 = rvalid1_r;
    assign rdata0  = rdata0_r;
    assign rdata1  = rdata1_r;
    assign fadd_x1 = fadd_x1_r;
    assign fadd_x2 = fadd_x2_r;
    assign busy    = (|stage_valid_r) | rvalid0_r | rvalid1_r;

endmodule

// File: tb/tb_fadd_arb.sv
// Bench for fadd_arb: behavioural adder, queue-based reference model, directed and random traffic.
module tb_fadd_arb;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        ack0, ack1, rvalid0, rvalid1, busy;
    logic [31:0] rdata0, rdata1, fadd_x1, fadd_x2, fadd_y;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        int          cyc;
        bit          id;
        logic [31:0] data;
    } obs_t;

    pend_t       pend[$];
    obs_t        obs[$];
    bit          fav_m;
    logic [31:0] last0_m, last1_m, x1_m, x2_m;
    logic [31:0] add_pipe [LAT];

    always #5 clk = ~clk;

    fadd_arb #(.FADD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
        .busy(busy)
    );

    function automatic real sp2real(input logic [31:0] v);
        int          ee;
        logic [63:0] d;
        if (v[30:23] == 8'd0) return 0.0;
        ee = int'(v[30:23]) - 127 + 1023;
        d  = {v[31], ee[10:0], v[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        int          ee;
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        ee = int'(d[62:52]) - 1023 + 127;
        return {d[63], ee[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int2sp(input int n);
        return real2sp(real'(n));
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input bit op);
        return real2sp(op ? sp2real(a) - sp2real(b) : sp2real(a) + sp2real(b));
    endfunction

    // Shared adder stand-in with LAT register stages.
    always @(posedge clk) begin
        add_pipe[0] <= real2sp(sp2real(fadd_x1) + sp2real(fadd_x2));
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign fadd_y = add_pipe[LAT-1];

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    endtask

    // One clock cycle: compare DUT against the model, then advance the model past the edge.
    task automatic step();
        bit          g0, g1, e_rv0, e_rv1, sop;
        logic [31:0] e_d0, e_d1, sa, sb;
        @(negedge clk);
        g0 = !rst && req0 && (!req1 || !fav_m);
        g1 = !rst && req1 && (!req0 || fav_m);
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_d0 = last0_m; e_d1 = last1_m;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (pend[i].id) begin e_rv1 = 1'b1; e_d1 = pend[i].data; end
                else begin e_rv0 = 1'b1; e_d0 = pend[i].data; end
            end
        end
        check32("ack0", 32'(ack0), 32'(g0));
        check32("ack1", 32'(ack1), 32'(g1));
        check32("rvalid0", 32'(rvalid0), 32'(e_rv0));
        check32("rvalid1", 32'(rvalid1), 32'(e_rv1));
        check32("rdata0", rdata0, e_d0);
        check32("rdata1", rdata1, e_d1);
        check32("busy", 32'(busy), 32'(pend.size() > 0));
        check32("fadd_x1", fadd_x1, x1_m);
        check32("fadd_x2", fadd_x2, x2_m);
        if (rvalid0) obs.push_back('{cyc, 1'b0, rdata0});
        if (rvalid1) obs.push_back('{cyc, 1'b1, rdata1});
        if (rst) begin
            pend.delete();
            fav_m = 1'b0; last0_m = 32'd0; last1_m = 32'd0; x1_m = 32'd0; x2_m = 32'd0;
        end else begin
            last0_m = e_d0; last1_m = e_d1;
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            if (g0 || g1) begin
                sa  = g1 ? a1 : a0;
                sb  = g1 ? b1 : b0;
                sop = g1 ? op1 : op0;
                pend.push_back('{cyc + LAT + 2, g1, ref_result(sa, sb, sop)});
                fav_m = !g1;
                x1_m  = sa;
                x2_m  = sop ? {~sb[31], sb[30:0]} : sb;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int g;
        logic [31:0] exp34 [3];
        rst = 1'b1;
        idle();
        fav_m = 1'b0; last0_m = 32'd0; last1_m = 32'd0; x1_m = 32'd0; x2_m = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1; req1 = 1'b1;
        step();
        rst = 1'b0;
        idle();
        step();

        // single add
        obs.delete();
        req0 = 1'b1; op0 = 1'b0; a0 = 32'h3F800000; b0 = 32'h40000000; g = cyc;
        step();
        idle();
        repeat (5) step();
        check32("add_count", 32'(obs.size()), 32'd1);
        check32("add_id", 32'(obs[0].id), 32'd0);
        check32("add_data", obs[0].data, 32'h40400000);
        check32("add_latency", 32'(obs[0].cyc - g), 32'd3);

        // subtract on requester 1
        obs.delete();
        req1 = 1'b1; op1 = 1'b1; a1 = 32'h40400000; b1 = 32'h3F800000; g = cyc;
        step();
        idle();
        repeat (5) step();
        check32("sub_count", 32'(obs.size()), 32'd1);
        check32("sub_id", 32'(obs[0].id), 32'd1);
        check32("sub_data", obs[0].data, 32'h40000000);
        check32("sub_latency", 32'(obs[0].cyc - g), 32'd3);

        // contention straight after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs.delete();
        req0 = 1'b1; req1 = 1'b1;
        a0 = 32'h3F800000; b0 = 32'h3F800000; a1 = 32'h40000000; b1 = 32'h40000000;
        g = cyc;
        repeat (4) step();
        idle();
        repeat (5) step();
        check32("rr_count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check32("rr_id", 32'(obs[i].id), 32'(i % 2));
            check32("rr_cycle", 32'(obs[i].cyc - g), 32'(i + 3));
        end

        // back-to-back single requester
        obs.delete();
        exp34[0] = 32'h40000000; exp34[1] = 32'h40800000; exp34[2] = 32'h40C00000;
        req0 = 1'b1; op0 = 1'b0; g = cyc;
        a0 = 32'h3F800000; b0 = 32'h3F800000; step();
        a0 = 32'h40000000; b0 = 32'h40000000; step();
        a0 = 32'h40400000; b0 = 32'h40400000; step();
        idle();
        repeat (5) step();
        check32("b2b_count", 32'(obs.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check32("b2b_data", obs[i].data, exp34[i]);
            check32("b2b_cycle", 32'(obs[i].cyc - g), 32'(i + 3));
        end

        // reset while an operation is in flight
        obs.delete();
        req0 = 1'b1; a0 = 32'h3F800000; b0 = 32'h3F800000;
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check32("flush_busy", 32'(busy), 32'd0);
        repeat (5) step();
        check32("flush_count", 32'(obs.size()), 32'd0);

        // exact cancellation
        obs.delete();
        req0 = 1'b1; op0 = 1'b1; a0 = 32'h3F800000; b0 = 32'h3F800000; g = cyc;
        step();
        idle();
        repeat (5) step();
        check32("cancel_count", 32'(obs.size()), 32'd1);
        check32("cancel_data", obs[0].data, 32'h00000000);

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            op0  = 1'($urandom_range(0, 1));
            op1  = 1'($urandom_range(0, 1));
            a0   = int2sp(int'($urandom_range(0, 1000)));
            b0   = int2sp(int'($urandom_range(0, 1000)));
            a1   = int2sp(int'($urandom_range(0, 1000)));
            b1   = int2sp(int'($urandom_range(0, 1000)));
            rst  = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fadd_arb.md
FADD_ARB -- requirements
Module: fadd_arb

Interface
REQ-001 SHALL have parameter FADD_LAT, default 1, meaning the register stages inside the shared adder between operand input and result output.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports req0/req1, input, 1 each, meaning requester n has an operation pending.
REQ-005 SHALL have ports op0/op1, input, 1 each: 0 = a+b, 1 = a-b.
REQ-006 SHALL have ports a0/b0/a1/b1, input, 32 each, IEEE-754 single operands.
REQ-007 SHALL have ports ack0/ack1, output, 1 each, meaning the request is accepted this cycle.
REQ-008 SHALL have ports rvalid0/rvalid1, output, 1 each, a one-cycle result strobe.
REQ-009 SHALL have ports rdata0/rdata1, output, 32 each, the result data.
REQ-010 SHALL have ports fadd_x1/fadd_x2, output, 32 each, operands to the shared adder.
REQ-011 SHALL have port fadd_y, input, 32, the adder result.
REQ-012 SHALL have port busy, output, 1, high while any accepted operation is unreturned.

Function
REQ-013 SHALL accept at most one request per cycle; a handshake is reqN=1 and ackN=1 in the same cycle.
REQ-014 SHALL drive ackN combinationally: only one requester asserting -> ack it; both asserting -> ack the one selected by rr_ptr.
REQ-015 SHALL keep a 1-bit rr_ptr; after any grant, rr_ptr = not(granted index); with no grant, rr_ptr holds.
REQ-016 SHALL hold ackN low for a requester whose reqN is low.
REQ-017 SHALL register operands on grant: fadd_x1 = a, fadd_x2 = b for op=0 or {~b[31], b[30:0]} for op=1. The registers hold their value when there is no grant.
REQ-018 SHALL track each accepted operation with a {valid, id} shift register of depth FADD_LAT+1, advanced every cycle.
REQ-019 SHALL sample fadd_y into an output register when the shift register's last stage is valid.
REQ-020 SHALL pulse rvalidN, with rdataN = sampled value, exactly 3 cycles after the grant cycle for FADD_LAT=1 (FADD_LAT+2 in general).
REQ-021 SHALL keep rdataN holding its last value while rvalidN is low.
REQ-022 SHALL be fully pipelined: back-to-back grants on consecutive cycles -> results on consecutive cycles, in grant order.
REQ-023 SHALL never assert rvalid0 and rvalid1 in the same cycle.
REQ-024 SHALL drive busy = OR of all shift-register valid bits and the output-stage valid.
REQ-025 SHALL NOT accept backpressure on results; the requester must consume rvalidN on the cycle it is asserted.
REQ-026 SHALL let a requester whose reqN stays high after ack issue a new operation with its current a/b/op in the next cycle, subject to arbitration.
REQ-027 SHALL perform no arithmetic itself beyond the sign flip; NaN, Inf and zero are passed through as fadd_y produces them.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear: all shift-register valids, rvalid0/1, rdata0/1 (to 0), fadd_x1/x2 (to 0), and rr_ptr (to 0, requester 0 favoured).
REQ-029 SHALL drop all in-flight operations on reset mid-operation; no rvalid is produced for them after rst falls.
REQ-030 SHALL hold ack0/ack1 low while rst=1.

Verification
REQ-031 Single add: req0, op0=0, a0=0x3F800000, b0=0x40000000 -> ack0 in the same cycle; rvalid0 3 cycles later with rdata0=0x40400000; rvalid1 stays 0.
REQ-032 Subtract: req1, op1=1, a1=0x40400000, b1=0x3F800000 -> rvalid1 3 cycles later with rdata1=0x40000000.
REQ-033 Contention: req0 and req1 held for 4 cycles after reset -> grants 0,1,0,1; rvalid alternates 0,1,0,1 on 4 consecutive cycles.
REQ-034 Back-to-back single requester: req0 held 3 cycles with operands (1,1), (2,2), (3,3) -> rdata0 = 0x40000000, 0x40800000, 0x40C00000 on consecutive cycles.
REQ-035 Reset mid-flight: grant req0, assert rst one cycle later -> no rvalid0 ever appears; busy=0 the cycle after rst.
REQ-036 Cancellation: a=b=0x3F800000, op=1 -> rdata=0x00000000; busy falls 1 cycle after the rvalid pulse.
